// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA FIFO sharing controller.
// Holds the write-side arbitration states and the requester id type.
package dma_pkg;

    localparam int DMA_DATA_WIDTH     = 512;
    localparam int DMA_FIFO_NUM_REQ   = 4;
    localparam int DMA_FIFO_MAX_BURST = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } dma_fifo_arb_state_e;

    typedef logic [$clog2(DMA_FIFO_NUM_REQ)-1:0] dma_req_id_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dma_fifo_ctrl_if.sv
// Bundle of requester, FIFO and consumer signals around dma_fifo_ctrl.
// Signal names are given from the controller's point of view (slave modport).
interface dma_fifo_ctrl_if #(
    parameter int NUM_REQ = dma_pkg::DMA_FIFO_NUM_REQ,
    parameter int WIDTH   = dma_pkg::DMA_DATA_WIDTH
) ();

    logic                              clear_i;
    logic [NUM_REQ-1:0]                req_valid_i;
    logic [NUM_REQ-1:0]                req_last_i;
    logic [NUM_REQ-1:0][WIDTH-1:0]     req_data_i;
    logic [NUM_REQ-1:0]                req_ready_o;
    logic                              fifo_write_o;
    logic [WIDTH-1:0]                  fifo_data_o;
    logic                              fifo_full_i;
    logic                              fifo_read_o;
    logic [WIDTH-1:0]                  fifo_data_i;
    logic                              fifo_empty_i;
    logic                              out_valid_o;
    logic [WIDTH-1:0]                  out_data_o;
    logic                              out_ready_i;
    logic [$clog2(NUM_REQ)-1:0]        grant_id_o;
    logic                              busy_o;

    modport slave (
        input  clear_i, req_valid_i, req_last_i, req_data_i,
        input  fifo_full_i, fifo_data_i, fifo_empty_i, out_ready_i,
        output req_ready_o, fifo_write_o, fifo_data_o, fifo_read_o,
        output out_valid_o, out_data_o, grant_id_o, busy_o
    );

    modport master (
        output clear_i, req_valid_i, req_last_i, req_data_i,
        output fifo_full_i, fifo_data_i, fifo_empty_i, out_ready_i,
        input  req_ready_o, fifo_write_o, fifo_data_o, fifo_read_o,
        input  out_valid_o, out_data_o, grant_id_o, busy_o
    );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping around; returns the one-hot winner and its index.
module dma_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/dma_fifo_ctrl.sv
// Shares the DMA data FIFO write port among NUM_REQ burst writers and turns
// the FIFO's 1-cycle read latency into a registered valid/ready stream.
module dma_fifo_ctrl
    import dma_pkg::*;
#(
    parameter int NUM_REQ   = DMA_FIFO_NUM_REQ,
    parameter int WIDTH     = DMA_DATA_WIDTH,
    parameter int MAX_BURST = DMA_FIFO_MAX_BURST
) (
    input logic            clk,
    input logic            rstn,
    dma_fifo_ctrl_if.slave bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    dma_fifo_arb_state_e state_q;
    logic [IDW-1:0]      grant_q;
    logic [IDW-1:0]      rrPtr_q;
    logic [CW-1:0]       beatCnt_q;

    logic [NUM_REQ-1:0]  winOneHot;
    logic [IDW-1:0]      winIdx;
    logic                winValid;
    logic [NUM_REQ-1:0]  reqReady;
    logic                accept;
    logic                burstEnd;

    dma_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (bus.req_valid_i),
        .ptr_i (rrPtr_q),
        .gnt_o (winOneHot),
        .idx_o (winIdx)
    );

    assign winValid = |winOneHot;

    always_comb begin
        reqReady = '0;
        if (state_q == BURST && !bus.fifo_full_i && !bus.clear_i) begin
            reqReady[grant_q] = 1'b1;
        end
    end

    assign accept   = bus.req_valid_i[grant_q] & reqReady[grant_q];
    assign burstEnd = accept & (bus.req_last_i[grant_q] | (beatCnt_q == CW'(MAX_BURST - 1)));

    assign bus.req_ready_o  = reqReady;
    assign bus.fifo_write_o = accept;
    assign bus.fifo_data_o  = bus.req_data_i[grant_q];
    assign bus.grant_id_o   = grant_q;

    // A grant is held until last or the beat cap, even if the owner goes quiet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rrPtr_q   <= '0;
            beatCnt_q <= '0;
        end else if (bus.clear_i) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winValid) begin
                        grant_q   <= winIdx;
                        beatCnt_q <= '0;
                        state_q   <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beatCnt_q <= beatCnt_q + 1'b1;
                    end
                    if (burstEnd) begin
                        state_q <= IDLE;
                        rrPtr_q <= IDW'(rr_next(int'(grant_q), NUM_REQ));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             inflight_q;
    logic             outValid_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] tail_d;
    logic             pop;
    logic [2:0]       occupancy;
    logic             fifoRead;

    assign pop       = outValid_q & bus.out_ready_i;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign fifoRead  = ~bus.fifo_empty_i & ~bus.clear_i & ((occupancy < 3'd2) | pop);

    // Pop shifts the tail forward before the returning read lands behind it.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end
        if (inflight_q) begin
            if (count_d == 2'd0) begin
                head_d = bus.fifo_data_i;
            end else begin
                tail_d = bus.fifo_data_i;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            outValid_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else if (bus.clear_i) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= fifoRead;
            outValid_q <= (count_d != 2'd0);
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign bus.fifo_read_o = fifoRead;
    assign bus.out_valid_o = outValid_q;
    assign bus.out_data_o  = head_q;
    assign bus.busy_o      = (state_q == BURST) | (count_q != 2'd0) | inflight_q;

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Scoreboard bench for dma_fifo_ctrl: behavioural requesters and FIFO model,
// expected FIFO writes and output beats queued at stimulus time.
module tb_dma_fifo_ctrl;
    import dma_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int WIDTH      = 32;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    typedef struct {
        dma_req_id_t      id;
        logic [WIDTH-1:0] data;
    } wrExp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    dma_fifo_ctrl_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    dma_fifo_ctrl #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycleCnt    = 0;
    int readCount   = 0;

    beat_t            reqQ [NUM_REQ][$];
    wrExp_t           wrExpQ[$];
    logic [WIDTH-1:0] outExpQ[$];
    int               wrCycles[$];
    int               outCycles[$];
    logic [WIDTH-1:0] fifoQ[$];

    logic [NUM_REQ-1:0]            reqValid   = '0;
    logic [NUM_REQ-1:0]            reqLast    = '0;
    logic [NUM_REQ-1:0][WIDTH-1:0] reqData    = '0;
    logic [NUM_REQ-1:0]            acceptMask = '0;
    logic                          clear      = 1'b0;
    logic                          outReady   = 1'b0;
    logic                          forceFull  = 1'b0;
    logic                          fifoEmptyQ = 1'b1;
    logic                          fifoFullQ  = 1'b0;
    logic [WIDTH-1:0]              fifoRdData = '0;
    logic                          wrCap      = 1'b0;
    logic                          rdCap      = 1'b0;
    logic [WIDTH-1:0]              wrDataCap  = '0;
    wrExp_t                        expW;
    logic [WIDTH-1:0]              expO;

    assign bus.clear_i      = clear;
    assign bus.req_valid_i  = reqValid;
    assign bus.req_last_i   = reqLast;
    assign bus.req_data_i   = reqData;
    assign bus.fifo_full_i  = forceFull | fifoFullQ;
    assign bus.fifo_empty_i = fifoEmptyQ;
    assign bus.fifo_data_i  = fifoRdData;
    assign bus.out_ready_i  = outReady;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [WIDTH-1:0] data, input logic last, input logic toOut);
        reqQ[id].push_back('{data: data, last: last});
        wrExpQ.push_back('{id: dma_req_id_t'(id), data: data});
        if (toOut) outExpQ.push_back(data);
    endtask

    task automatic clearPulse();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((wrExpQ.size() != 0 || outExpQ.size() != 0) && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput({name, " drained in time"}, 64'(n < 500), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitWrites(input string name, input int num);
        int n;
        n = 0;
        while (wrCycles.size() < num && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput({name, " write seen in time"}, 64'(n < 200), 64'd1);
    endtask

    // Monitor: everything sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        acceptMask = bus.req_valid_i & bus.req_ready_o;
        wrCap      = bus.fifo_write_o;
        wrDataCap  = bus.fifo_data_o;
        rdCap      = bus.fifo_read_o;
        if (rdCap) readCount++;
        if (bus.fifo_write_o) begin
            wrCycles.push_back(cycleCnt);
            if (wrExpQ.size() == 0) begin
                checkOutput("unexpected fifo write", 64'd1, 64'd0);
            end else begin
                expW = wrExpQ.pop_front();
                checkOutput("write grant", 64'(bus.grant_id_o), 64'(expW.id));
                checkOutput("write data", 64'(bus.fifo_data_o), 64'(expW.data));
            end
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
            outCycles.push_back(cycleCnt);
            if (outExpQ.size() == 0) begin
                checkOutput("unexpected out beat", 64'd1, 64'd0);
            end else begin
                expO = outExpQ.pop_front();
                checkOutput("out data", 64'(bus.out_data_o), 64'(expO));
            end
        end
    end

    // Behavioural requesters: present the head beat, retire it once accepted.
    always @(posedge clk) begin
        cycleCnt++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acceptMask[i] && reqQ[i].size() != 0) void'(reqQ[i].pop_front());
            if (reqQ[i].size() != 0) begin
                reqValid[i] <= 1'b1;
                reqData[i]  <= reqQ[i][0].data;
                reqLast[i]  <= reqQ[i][0].last;
            end else begin
                reqValid[i] <= 1'b0;
                reqLast[i]  <= 1'b0;
            end
        end
    end

    // FIFO model with one cycle of read latency.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifoQ.delete();
            fifoEmptyQ <= 1'b1;
            fifoFullQ  <= 1'b0;
            fifoRdData <= '0;
        end else begin
            if (rdCap) begin
                if (fifoQ.size() != 0) fifoRdData <= fifoQ.pop_front();
                else checkOutput("fifo read while empty", 64'd1, 64'd0);
            end
            if (wrCap) fifoQ.push_back(wrDataCap);
            fifoEmptyQ <= (fifoQ.size() == 0);
            fifoFullQ  <= (fifoQ.size() >= FIFO_DEPTH);
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int mark;
        int n;
        int releaseCycle;

        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checkOutput("reset out_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("reset req_ready", 64'(bus.req_ready_o), 64'd0);
        checkOutput("reset fifo_write", 64'(bus.fifo_write_o), 64'd0);
        checkOutput("reset fifo_read", 64'(bus.fifo_read_o), 64'd0);
        checkOutput("reset grant", 64'(bus.grant_id_o), 64'd0);
        checkOutput("reset busy", 64'(bus.busy_o), 64'd0);

        $display("[TB] single requester");
        clearPulse();
        outReady = 1'b1;
        wrCycles.delete(); outCycles.delete();
        applyStimulus(2, 32'hA, 1'b0, 1'b1);
        applyStimulus(2, 32'hB, 1'b0, 1'b1);
        applyStimulus(2, 32'hC, 1'b1, 1'b1);
        waitDrain("single");
        checkOutput("single write count", 64'(wrCycles.size()), 64'd3);
        checkOutput("single out count", 64'(outCycles.size()), 64'd3);
        if (wrCycles.size() == 3 && outCycles.size() == 3) begin
            for (int k = 1; k < 3; k++) begin
                checkOutput("single write gap", 64'(wrCycles[k] - wrCycles[k-1]), 64'd1);
                checkOutput("single out gap", 64'(outCycles[k] - outCycles[k-1]), 64'd1);
            end
            checkOutput("single read latency", 64'(outCycles[0] - wrCycles[0]), 64'd3);
        end
        checkOutput("single idle busy", 64'(bus.busy_o), 64'd0);
        checkOutput("single last grant", 64'(bus.grant_id_o), 64'd2);

        $display("[TB] round robin");
        clearPulse();
        wrCycles.delete();
        applyStimulus(0, 32'h100, 1'b1, 1'b1);
        applyStimulus(1, 32'h101, 1'b1, 1'b1);
        applyStimulus(2, 32'h102, 1'b1, 1'b1);
        applyStimulus(3, 32'h103, 1'b1, 1'b1);
        applyStimulus(0, 32'h104, 1'b1, 1'b1);
        waitDrain("rr");
        checkOutput("rr write count", 64'(wrCycles.size()), 64'd5);
        for (int k = 1; k < wrCycles.size(); k++) begin
            checkOutput("rr grant gap", 64'(wrCycles[k] - wrCycles[k-1]), 64'd2);
        end

        $display("[TB] burst cap");
        clearPulse();
        wrCycles.delete();
        for (int k = 1; k <= 16; k++) applyStimulus(1, 32'h200 + 32'(k), 1'b0, 1'b1);
        applyStimulus(3, 32'h300, 1'b1, 1'b1);
        for (int k = 17; k <= 20; k++) applyStimulus(1, 32'h200 + 32'(k), 1'b0, 1'b1);
        waitDrain("cap");
        checkOutput("cap write count", 64'(wrCycles.size()), 64'd21);
        if (wrCycles.size() == 21) begin
            checkOutput("cap handover gap", 64'(wrCycles[16] - wrCycles[15]), 64'd2);
            checkOutput("cap resume gap", 64'(wrCycles[17] - wrCycles[16]), 64'd2);
        end
        checkOutput("cap grant held", 64'(bus.grant_id_o), 64'd1);
        checkOutput("cap burst open", 64'(bus.busy_o), 64'd1);

        $display("[TB] back-pressure");
        clearPulse();
        wrCycles.delete();
        applyStimulus(0, 32'h400, 1'b0, 1'b1);
        applyStimulus(0, 32'h401, 1'b0, 1'b1);
        applyStimulus(0, 32'h402, 1'b0, 1'b1);
        applyStimulus(0, 32'h403, 1'b1, 1'b1);
        waitWrites("bp", 1);
        @(posedge clk); #1 forceFull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp ready low", 64'(bus.req_ready_o), 64'd0);
            checkOutput("bp no write", 64'(bus.fifo_write_o), 64'd0);
            checkOutput("bp grant held", 64'(bus.grant_id_o), 64'd0);
            checkOutput("bp busy", 64'(bus.busy_o), 64'd1);
        end
        @(posedge clk); #1 forceFull = 1'b0;
        releaseCycle = cycleCnt;
        waitDrain("bp");
        checkOutput("bp write count", 64'(wrCycles.size()), 64'd4);
        if (wrCycles.size() == 4) begin
            checkOutput("bp resume cycle", 64'(wrCycles[1]), 64'(releaseCycle));
            checkOutput("bp tail gap", 64'(wrCycles[3] - wrCycles[1]), 64'd2);
        end

        $display("[TB] read stall");
        clearPulse();
        outReady = 1'b0;
        outCycles.delete();
        mark = readCount;
        applyStimulus(2, 32'h500, 1'b0, 1'b1);
        applyStimulus(2, 32'h501, 1'b0, 1'b1);
        applyStimulus(2, 32'h502, 1'b0, 1'b1);
        applyStimulus(2, 32'h503, 1'b1, 1'b1);
        repeat (15) @(negedge clk);
        checkOutput("stall read count", 64'(readCount - mark), 64'd2);
        checkOutput("stall read low", 64'(bus.fifo_read_o), 64'd0);
        checkOutput("stall out_valid", 64'(bus.out_valid_o), 64'd1);
        checkOutput("stall head", 64'(bus.out_data_o), 64'h500);
        checkOutput("stall busy", 64'(bus.busy_o), 64'd1);
        @(posedge clk); #1 outReady = 1'b1;
        waitDrain("stall");
        checkOutput("stall out count", 64'(outCycles.size()), 64'd4);
        for (int k = 1; k < outCycles.size(); k++) begin
            checkOutput("stall out gap", 64'(outCycles[k] - outCycles[k-1]), 64'd1);
        end

        $display("[TB] clear with read in flight");
        clearPulse();
        outReady = 1'b0;
        applyStimulus(0, 32'h600, 1'b0, 1'b0);
        applyStimulus(0, 32'h601, 1'b1, 1'b0);
        n = 0;
        while (!bus.out_valid_o && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("clear setup reached", 64'(n < 50), 64'd1);
        checkOutput("clear setup busy", 64'(bus.busy_o), 64'd1);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        checkOutput("clear out_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("clear busy", 64'(bus.busy_o), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("clear data dropped", 64'(bus.out_valid_o), 64'd0);
        checkOutput("clear stays idle", 64'(bus.busy_o), 64'd0);
        checkOutput("pending writes", 64'(wrExpQ.size()), 64'd0);
        checkOutput("pending out beats", 64'(outExpQ.size()), 64'd0);

        $display("[TB] reset mid-burst");
        clearPulse();
        outReady = 1'b1;
        wrCycles.delete();
        for (int k = 0; k < 6; k++) applyStimulus(1, 32'h700 + 32'(k), (k == 5), 1'b1);
        waitWrites("rst", 2);
        @(posedge clk); #2 rstn = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
        wrExpQ.delete();
        outExpQ.delete();
        #1;
        checkOutput("async reset req_ready", 64'(bus.req_ready_o), 64'd0);
        checkOutput("async reset fifo_write", 64'(bus.fifo_write_o), 64'd0);
        checkOutput("async reset fifo_read", 64'(bus.fifo_read_o), 64'd0);
        checkOutput("async reset out_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("async reset out_data", 64'(bus.out_data_o), 64'd0);
        checkOutput("async reset grant", 64'(bus.grant_id_o), 64'd0);
        checkOutput("async reset busy", 64'(bus.busy_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
